// File: rtl/ddmtd_pkg.sv
// Shared definitions for the DDMTD deglitcher: FSM encoding, default
// parameter values and a small saturating-increment helper.
package ddmtd_pkg;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_THRESH    = 8;

  typedef enum logic [1:0] {
    ST_WAIT_LOW  = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_CONFIRM   = 2'd2
  } state_e;

  // Increment an 8-bit count, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ddmtd_deglitcher_if.sv
// Sample input and tag/period result bundle of the DDMTD deglitcher.
//
// Handshake: there is no backpressure. tag_valid_o and period_valid_o are
// single-cycle pulses; tag_o / period_o are valid in the pulse cycle and hold
// their value until the next pulse. The consumer must accept every pulse.
interface ddmtd_deglitcher_if #(
  parameter int CNT_WIDTH = ddmtd_pkg::DEF_CNT_WIDTH
);
  logic                 clk_sampled_i;
  logic [CNT_WIDTH-1:0] tag_o;
  logic                 tag_valid_o;
  logic [CNT_WIDTH-1:0] period_o;
  logic                 period_valid_o;
  logic [7:0]           glitch_cnt_o;

  // Upstream sampler / result consumer side.
  modport master (
    output clk_sampled_i,
    input  tag_o, tag_valid_o, period_o, period_valid_o, glitch_cnt_o
  );

  // Deglitcher side.
  modport slave (
    input  clk_sampled_i,
    output tag_o, tag_valid_o, period_o, period_valid_o, glitch_cnt_o
  );
endinterface

// File: rtl/ddmtd_tag_counter.sv
// Free-running wrap-around tag counter used as the timestamp base.
module ddmtd_tag_counter #(
  parameter int CNT_WIDTH = ddmtd_pkg::DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Count every cycle, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ddmtd_deglitcher.sv
// DDMTD beat-signal deglitcher: accepts a rising edge only after THRESH
// stable lows followed by THRESH stable highs, timestamps it with the tag
// counter value of the first high sample and reports the edge-to-edge period.
module ddmtd_deglitcher
  import ddmtd_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int THRESH    = DEF_THRESH
) (
  input  logic            clk_ddmtd_i,
  input  logic            rst_ddmtdclk_i,
  ddmtd_deglitcher_if.slave bus,
  output state_e          o_state
);

  localparam logic [7:0] TH8   = THRESH[7:0];
  localparam logic [7:0] TH_M1 = TH8 - 8'd1;

  logic [CNT_WIDTH-1:0] w_cnt;
  logic                 w_sample;

  state_e               r_state;
  logic [7:0]           r_stable;
  logic [CNT_WIDTH-1:0] r_hold;
  logic [CNT_WIDTH-1:0] r_prev;
  logic                 r_first;
  logic [CNT_WIDTH-1:0] r_tag;
  logic                 r_tag_valid;
  logic [CNT_WIDTH-1:0] r_period;
  logic                 r_period_valid;
  logic [7:0]           r_glitch;

  assign w_sample = bus.clk_sampled_i;

  ddmtd_tag_counter #(.CNT_WIDTH(CNT_WIDTH)) u_tag_counter (
    .i_clk (clk_ddmtd_i),
    .i_rst (rst_ddmtdclk_i),
    .o_cnt (w_cnt)
  );

  // Edge qualification FSM plus tag/period/glitch datapath, all registered.
  always_ff @(posedge clk_ddmtd_i) begin
    if (rst_ddmtdclk_i) begin
      r_state        <= ST_WAIT_LOW;
      r_stable       <= '0;
      r_hold         <= '0;
      r_prev         <= '0;
      r_first        <= 1'b1;
      r_tag          <= '0;
      r_tag_valid    <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_glitch       <= '0;
    end else begin
      r_tag_valid    <= 1'b0;
      r_period_valid <= 1'b0;
      case (r_state)
        ST_WAIT_LOW: begin
          if (!w_sample) begin
            if (r_stable == TH_M1) begin
              r_stable <= '0;
              r_state  <= ST_WAIT_EDGE;
            end else begin
              r_stable <= r_stable + 8'd1;
            end
          end else begin
            r_stable <= '0;
          end
        end
        ST_WAIT_EDGE: begin
          if (w_sample) begin
            r_hold <= w_cnt;
            if (THRESH == 1) begin
              // A single high sample is enough: publish straight away.
              r_tag       <= w_cnt;
              r_tag_valid <= 1'b1;
              r_prev      <= w_cnt;
              r_first     <= 1'b0;
              if (!r_first) begin
                r_period       <= w_cnt - r_prev;
                r_period_valid <= 1'b1;
              end
              r_stable <= '0;
              r_state  <= ST_WAIT_LOW;
            end else begin
              r_stable <= 8'd1;
              r_state  <= ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (w_sample) begin
            if (r_stable == TH_M1) begin
              r_tag       <= r_hold;
              r_tag_valid <= 1'b1;
              r_prev      <= r_hold;
              r_first     <= 1'b0;
              if (!r_first) begin
                r_period       <= r_hold - r_prev;
                r_period_valid <= 1'b1;
              end
              r_stable <= '0;
              r_state  <= ST_WAIT_LOW;
            end else begin
              r_stable <= r_stable + 8'd1;
            end
          end else begin
            // High run too short: a glitch; the next rising edge re-stamps.
            r_glitch <= sat_inc8(r_glitch);
            r_stable <= '0;
            r_state  <= ST_WAIT_EDGE;
          end
        end
        default: begin
          r_stable <= '0;
          r_state  <= ST_WAIT_LOW;
        end
      endcase
    end
  end

  assign bus.tag_o          = r_tag;
  assign bus.tag_valid_o    = r_tag_valid;
  assign bus.period_o       = r_period;
  assign bus.period_valid_o = r_period_valid;
  assign bus.glitch_cnt_o   = r_glitch;
  assign o_state            = r_state;

endmodule

// File: tb/tb_ddmtd_deglitcher.sv
// Bench for ddmtd_deglitcher with CNT_WIDTH=16, THRESH=4: directed
// scenarios plus random bursts, checked cycle by cycle against a
// run-length reference model and a tag scoreboard.
module tb_ddmtd_deglitcher;
  import ddmtd_pkg::*;

  localparam int CW = 16;
  localparam int TH = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;

  always #5 clk = ~clk;

  ddmtd_deglitcher_if #(.CNT_WIDTH(CW)) bus ();

  ddmtd_deglitcher #(.CNT_WIDTH(CW), .THRESH(TH)) dut (
    .clk_ddmtd_i    (clk),
    .rst_ddmtdclk_i (rst),
    .bus            (bus),
    .o_state        (dbg_state)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_q[$];

  int            m_cnt;
  bit            m_armed;
  int            m_zrun;
  int            m_run;
  logic [CW-1:0] m_start;
  logic [CW-1:0] m_prev;
  bit            m_have_prev;

  logic [CW-1:0] e_tag;
  bit            e_tv;
  logic [CW-1:0] e_period;
  bit            e_pv;
  int            e_glitch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cnt=%0h)", tag, got, exp, m_cnt);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_armed = 0; m_zrun = 0; m_run = 0;
    m_start = '0; m_prev = '0; m_have_prev = 0;
    e_tag = '0; e_tv = 0; e_period = '0; e_pv = 0; e_glitch = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [CW-1:0] t);
    e_tag = t;
    e_tv  = 1;
    exp_q.push_back(t);
    if (m_have_prev) begin
      e_period = t - m_prev;
      e_pv     = 1;
    end
    m_prev      = t;
    m_have_prev = 1;
  endtask

  // One cycle of the reference: a low run of TH arms the detector, a high
  // run of TH while armed is an accepted edge stamped at its first sample,
  // a high run cut short while armed is a glitch.
  task automatic model_step(input bit s);
    e_tv = 0;
    e_pv = 0;
    if (!m_armed) begin
      if (!s) m_zrun++;
      else    m_zrun = 0;
      if (m_zrun == TH) begin
        m_armed = 1;
        m_zrun  = 0;
      end
    end else if (s) begin
      if (m_run == 0) m_start = m_cnt[CW-1:0];
      m_run++;
      if (m_run == TH) begin
        model_accept(m_start);
        m_armed = 0;
        m_run   = 0;
      end
    end else begin
      if (m_run > 0 && e_glitch < 255) e_glitch++;
      m_run = 0;
    end
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic compare_all(input string pfx);
    logic [CW-1:0] sb;
    check({pfx, "_tag_valid"}, 32'(bus.tag_valid_o), 32'(e_tv));
    check({pfx, "_tag"}, 32'(bus.tag_o), 32'(e_tag));
    check({pfx, "_period_valid"}, 32'(bus.period_valid_o), 32'(e_pv));
    check({pfx, "_period"}, 32'(bus.period_o), 32'(e_period));
    check({pfx, "_glitch"}, 32'(bus.glitch_cnt_o), 32'(e_glitch));
    if (bus.tag_valid_o) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_tag", 32'(bus.tag_o), 32'hFFFF_FFFF);
      end else begin
        sb = exp_q.pop_front();
        check("sb_tag", 32'(bus.tag_o), 32'(sb));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s, input bit do_chk = 1'b1);
    bus.clk_sampled_i = s;
    model_step(s);
    @(posedge clk);
    #1;
    if (do_chk) compare_all("cyc");
  endtask

  task automatic drive_until(input int target, input bit s, input bit dense = 1'b1);
    int guard = 0;
    while (m_cnt != target && guard < 70000) begin
      drive(s, dense || (m_cnt[7:0] == 8'h00));
      guard++;
    end
    check("until_bound", 32'(m_cnt), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.clk_sampled_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all("rst");
    check("rst_state", 32'(dbg_state), 32'(ST_WAIT_LOW));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    bit val;
    bus.clk_sampled_i = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset();

    // First clean edge at 0x0010: no period yet.
    drive_until(16'h0010, 1'b0);
    repeat (TH) drive(1'b1);
    check("e1_tv", 32'(bus.tag_valid_o), 32'd1);
    check("e1_tag", 32'(bus.tag_o), 32'h0010);
    check("e1_pv", 32'(bus.period_valid_o), 32'd0);

    // Second clean edge at 0x0110.
    drive_until(16'h0110, 1'b0);
    repeat (TH) drive(1'b1);
    check("e2_tag", 32'(bus.tag_o), 32'h0110);
    check("e2_period", 32'(bus.period_o), 32'h0100);
    check("e2_pv", 32'(bus.period_valid_o), 32'd1);

    // Glitch 1,1,0 then a clean edge at 0x0200.
    drive_until(16'h01F0, 1'b0);
    drive(1'b1); drive(1'b1); drive(1'b0);
    drive_until(16'h0200, 1'b0);
    repeat (TH) drive(1'b1);
    check("g_tag", 32'(bus.tag_o), 32'h0200);
    check("g_glitch", 32'(bus.glitch_cnt_o), 32'd1);

    // 300 glitches saturate the glitch counter.
    repeat (TH) drive(1'b0);
    repeat (300) begin
      drive(1'b1);
      drive(1'b0);
    end
    check("sat_glitch", 32'(bus.glitch_cnt_o), 32'd255);

    // Random bursts of lows and highs.
    repeat (1500) begin
      len = $urandom_range(1, 6);
      val = 1'($urandom_range(0, 1));
      repeat (len) drive(val);
    end

    // Reset two cycles into CONFIRM discards the pending tag.
    repeat (TH) drive(1'b0);
    drive(1'b1);
    drive(1'b1);
    check("pre_rst_state", 32'(dbg_state), 32'(ST_CONFIRM));
    do_reset();
    check("mid_rst_glitch", 32'(bus.glitch_cnt_o), 32'd0);
    check("mid_rst_tag", 32'(bus.tag_o), 32'd0);
    repeat (TH) drive(1'b0);
    repeat (TH) drive(1'b1);
    check("post_rst_tv", 32'(bus.tag_valid_o), 32'd1);
    check("post_rst_tag", 32'(bus.tag_o), 32'h0004);
    check("post_rst_pv", 32'(bus.period_valid_o), 32'd0);

    // Period across counter wrap: 0xFFF0 -> 0x0030.
    drive_until(16'hFFF0, 1'b0, 1'b0);
    repeat (TH) drive(1'b1);
    check("w1_tag", 32'(bus.tag_o), 32'hFFF0);
    drive_until(16'h0030, 1'b0);
    repeat (TH) drive(1'b1);
    check("w2_tag", 32'(bus.tag_o), 32'h0030);
    check("w2_period", 32'(bus.period_o), 32'h0040);
    check("w2_pv", 32'(bus.period_valid_o), 32'd1);

    // Pulses are single-cycle.
    drive(1'b1);
    check("pulse_tv_drop", 32'(bus.tag_valid_o), 32'd0);
    check("pulse_pv_drop", 32'(bus.period_valid_o), 32'd0);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
